axi_wr_responder: RTL and testbench

AXI_WR_RESPONDER -- requirements
Module: axi_wr_responder

---
 rtl/axi_wr_responder_if.sv | 34 +++
 rtl/axi_wr_responder.sv | 162 ++++++++++++++++
 tb/tb_axi_wr_responder.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_responder_if.sv
// AW/W/B handshake bundle for the AXI write responder, plus its FIFO occupancy.
// The responder binds to the slave modport; the traffic source uses master.
interface axi_wr_responder_if #(
    parameter int ID_WIDTH = 4,
    parameter int DEPTH    = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                awvalid;
    logic                awready;
    logic [ID_WIDTH-1:0] awid;

    logic                wvalid;
    logic                wready;
    logic                wlast;
    logic [3:0]          wstrb;

    logic                bvalid;
    logic                bready;
    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;

    logic [CNT_W-1:0]    outstanding;

    modport master (
        output awvalid, awid, wvalid, wlast, wstrb, bready,
        input  awready, wready, bvalid, bid, bresp, outstanding
    );

    modport slave (
        input  awvalid, awid, wvalid, wlast, wstrb, bready,
        output awready, wready, bvalid, bid, bresp, outstanding
    );
endinterface

// File: rtl/axi_wr_responder.sv
// In-order AXI write-response generator: queues AW IDs, counts finished W bursts
// and issues one B per burst in AW order. Define AXI_WR_RESP_ERR_EN for SLVERR on empty-strobe beats.
module axi_wr_responder #(
    parameter int ID_WIDTH = 4,
    parameter int DEPTH    = 16
) (
    input  logic              clk,
    input  logic              reset,
    axi_wr_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic {
        B_IDLE = 1'b0,
        B_BUSY = 1'b1
    } b_state_t;

    b_state_t            state_reg;
    b_state_t            state_next;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CNT_W-1:0]    wr_ptr_reg;
    logic [CNT_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    wdone_reg;
    logic [CNT_W-1:0]    wdone_next;
    logic [CNT_W-1:0]    outstanding;

    logic [ID_WIDTH-1:0] id_mem [DEPTH];
    logic [ID_WIDTH-1:0] bid_reg;
    logic [1:0]          bresp_reg;
    logic [1:0]          head_resp;

    logic                awready_int;
    logic                wready_int;
    logic                aw_fire;
    logic                w_fire;
    logic                wlast_fire;
    logic                load;

    assign outstanding = wr_ptr_reg - rd_ptr_reg;
    assign awready_int = (outstanding != FULL_CNT);
    // A beat may only flow once its AW is queued, i.e. some entry still awaits its burst.
    assign wready_int  = (outstanding > wdone_reg);

    assign aw_fire    = bus.awvalid && awready_int;
    assign w_fire     = bus.wvalid && wready_int;
    assign wlast_fire = w_fire && bus.wlast;

    // B register control: refill from the FIFO head whenever the slot is free or being drained.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            B_IDLE: begin
                if (wdone_reg != '0) begin
                    load       = 1'b1;
                    state_next = B_BUSY;
                end
            end
            B_BUSY: begin
                if (bus.bready) begin
                    if (wdone_reg != '0) begin
                        load = 1'b1;
                    end else begin
                        state_next = B_IDLE;
                    end
                end
            end
            default: state_next = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= B_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A burst finishing in the same cycle as a load leaves the count unchanged.
    always_comb begin
        wdone_next = wdone_reg;
        if (wlast_fire && !load) begin
            wdone_next = wdone_reg + ONE_CNT;
        end else if (!wlast_fire && load) begin
            wdone_next = wdone_reg - ONE_CNT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            wdone_reg  <= '0;
            bid_reg    <= '0;
            bresp_reg  <= 2'b00;
        end else begin
            wdone_reg <= wdone_next;
            if (aw_fire) begin
                wr_ptr_reg <= wr_ptr_reg + ONE_CNT;
            end
            if (load) begin
                rd_ptr_reg <= rd_ptr_reg + ONE_CNT;
                bid_reg    <= id_mem[rd_ptr_reg[IDX_W-1:0]];
                bresp_reg  <= head_resp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aw_fire) begin
            id_mem[wr_ptr_reg[IDX_W-1:0]] <= bus.awid;
        end
    end

`ifdef AXI_WR_RESP_ERR_EN
    // Bursts complete in AW order, so a private write pointer tracks the entry being filled.
    logic [IDX_W-1:0] err_ptr_reg;
    logic             burst_err_reg;
    logic             beat_err;
    logic             err_mem [DEPTH];

    assign beat_err = (bus.wstrb == 4'b0000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_ptr_reg   <= '0;
            burst_err_reg <= 1'b0;
        end else if (w_fire) begin
            if (bus.wlast) begin
                err_ptr_reg   <= err_ptr_reg + 1'b1;
                burst_err_reg <= 1'b0;
            end else begin
                burst_err_reg <= burst_err_reg | beat_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wlast_fire) begin
            err_mem[err_ptr_reg] <= burst_err_reg | beat_err;
        end
    end

    assign head_resp = err_mem[rd_ptr_reg[IDX_W-1:0]] ? 2'b10 : 2'b00;
`else
    logic unused_wstrb;
    assign unused_wstrb = ^bus.wstrb;
    assign head_resp    = 2'b00;
`endif

    assign bus.awready     = awready_int;
    assign bus.wready      = wready_int;
    assign bus.bvalid      = (state_reg == B_BUSY);
    assign bus.bid         = bid_reg;
    assign bus.bresp       = bresp_reg;
    assign bus.outstanding = outstanding;
endmodule

// File: tb/tb_axi_wr_responder.sv
// Self-checking bench for axi_wr_responder: scoreboard of expected B responses
// filled at AW acceptance, checked every cycle bvalid is high.
`timescale 1ns/1ps
module tb_axi_wr_responder;
    localparam int ID_WIDTH = 4;
    localparam int DEPTH    = 16;
    localparam int TIMEOUT  = 300;
`ifdef AXI_WR_RESP_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif
    localparam logic [1:0] RESP_BAD = ERR_ON ? 2'b10 : 2'b00;

    logic clk = 1'b0;
    logic reset;

    axi_wr_responder_if #(.ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH)) bus ();

    axi_wr_responder #(.ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_WIDTH-1:0] id;
        logic [1:0]          resp;
    } exp_t;

    typedef struct {
        logic [ID_WIDTH-1:0] id;
        int                  beats;
        int                  zero_beat;
        logic [1:0]          exp_resp;
        bit                  tog;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    bit   toggle_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no handshake within %0d cycles, expected one", name, TIMEOUT);
    endtask

    // Every bvalid cycle must show the scoreboard head; a pop happens only on bready.
    task automatic mon();
        if (!reset && bus.bvalid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_b: got bid %0h with nothing pending, expected no bvalid", bus.bid);
            end else begin
                check("bid", 32'(bus.bid), 32'(sb_q[0].id));
                check("bresp", 32'(bus.bresp), 32'(sb_q[0].resp));
                $display("B bid=%0h bresp=%0b bready=%0b", bus.bid, bus.bresp, bus.bready);
                if (bus.bready) void'(sb_q.pop_front());
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        mon();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (toggle_en) bus.bready = ~bus.bready;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic do_aw(input logic [ID_WIDTH-1:0] id, input logic [1:0] resp);
        bus.awvalid = 1'b1;
        bus.awid    = id;
        for (int n = 0; n <= TIMEOUT; n++) begin
            sample();
            if (bus.awready) begin
                sb_q.push_back('{id: id, resp: resp});
                $display("AW id=%0h", id);
                advance();
                break;
            end
            if (n == TIMEOUT) timeout("aw_accept");
            advance();
        end
        bus.awvalid = 1'b0;
    endtask

    task automatic do_w(input int beats, input int zero_beat);
        for (int b = 0; b < beats; b++) begin
            bus.wvalid = 1'b1;
            bus.wlast  = (b == beats - 1);
            bus.wstrb  = (b == zero_beat) ? 4'h0 : 4'hF;
            for (int n = 0; n <= TIMEOUT; n++) begin
                sample();
                if (bus.wready) begin
                    advance();
                    break;
                end
                if (n == TIMEOUT) timeout("w_accept");
                advance();
            end
        end
        $display("W burst beats=%0d zero_beat=%0d", beats, zero_beat);
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        bus.wstrb  = 4'hF;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < TIMEOUT) begin
            cycle();
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d responses still pending, expected 0", name, sb_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{id: 4'h1, beats: 1,  zero_beat: -1, exp_resp: 2'b00,    tog: 1'b0};
        vecs[1] = '{id: 4'hA, beats: 4,  zero_beat: -1, exp_resp: 2'b00,    tog: 1'b0};
        vecs[2] = '{id: 4'h7, beats: 4,  zero_beat: 1,  exp_resp: RESP_BAD, tog: 1'b0};
        vecs[3] = '{id: 4'h7, beats: 4,  zero_beat: -1, exp_resp: 2'b00,    tog: 1'b0};
        vecs[4] = '{id: 4'hF, beats: 8,  zero_beat: 7,  exp_resp: RESP_BAD, tog: 1'b1};
        vecs[5] = '{id: 4'h0, beats: 2,  zero_beat: 0,  exp_resp: RESP_BAD, tog: 1'b1};
        vecs[6] = '{id: 4'hC, beats: 16, zero_beat: -1, exp_resp: 2'b00,    tog: 1'b1};
        vecs[7] = '{id: 4'h3, beats: 3,  zero_beat: -1, exp_resp: 2'b00,    tog: 1'b0};

        reset       = 1'b1;
        bus.awvalid = 1'b0;
        bus.awid    = '0;
        bus.wvalid  = 1'b0;
        bus.wlast   = 1'b0;
        bus.wstrb   = 4'hF;
        bus.bready  = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;

        // Reset state
        sample();
        check("rst_awready", 32'(bus.awready), 32'd1);
        check("rst_wready", 32'(bus.wready), 32'd0);
        check("rst_bvalid", 32'(bus.bvalid), 32'd0);
        check("rst_bid", 32'(bus.bid), 32'd0);
        check("rst_bresp", 32'(bus.bresp), 32'd0);
        check("rst_outstanding", 32'(bus.outstanding), 32'd0);
        advance();

        // Single beat, minimum latency
        do_aw(4'h5, 2'b00);
        bus.wvalid = 1'b1;
        bus.wlast  = 1'b1;
        sample();
        check("t1_outstanding", 32'(bus.outstanding), 32'd1);
        check("t1_wready", 32'(bus.wready), 32'd1);
        check("t1_bvalid_pre", 32'(bus.bvalid), 32'd0);
        advance();
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        sample();
        check("t1_latency", 32'(bus.bvalid), 32'd0);
        advance();
        sample();
        check("t1_bvalid", 32'(bus.bvalid), 32'd1);
        check("t1_bid", 32'(bus.bid), 32'h5);
        check("t1_outstanding_after", 32'(bus.outstanding), 32'd0);
        advance();
        sample();
        check("t1_bvalid_done", 32'(bus.bvalid), 32'd0);
        advance();

        // Fill the AW queue, then a 17th AW stalls until one B completes
        for (int i = 0; i < DEPTH; i++) do_aw(4'(i), 2'b00);
        sample();
        check("t2_outstanding_full", 32'(bus.outstanding), 32'd16);
        check("t2_awready_full", 32'(bus.awready), 32'd0);
        advance();
        bus.awvalid = 1'b1;
        bus.awid    = 4'h9;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("t2_stall", 32'(bus.awready), 32'd0);
            advance();
        end
        bus.wvalid = 1'b1;
        bus.wlast  = 1'b1;
        sample();
        check("t2_awready_w", 32'(bus.awready), 32'd0);
        check("t2_wready", 32'(bus.wready), 32'd1);
        advance();
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        sample();
        check("t2_awready_wdone", 32'(bus.awready), 32'd0);
        advance();
        sample();
        check("t2_awready_pop", 32'(bus.awready), 32'd1);
        if (bus.awready) sb_q.push_back('{id: 4'h9, resp: 2'b00});
        advance();
        bus.awvalid = 1'b0;
        sample();
        check("t2_outstanding_refill", 32'(bus.outstanding), 32'd16);
        advance();
        for (int i = 0; i < DEPTH; i++) do_w(1, -1);
        drain("t2_drain");

        // W before AW stalls; AW arrival releases it next cycle
        bus.wvalid = 1'b1;
        bus.wlast  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample();
            check("t3_wready_noaw", 32'(bus.wready), 32'd0);
            advance();
        end
        bus.awvalid = 1'b1;
        bus.awid    = 4'h3;
        sample();
        check("t3_wready_same", 32'(bus.wready), 32'd0);
        check("t3_awready", 32'(bus.awready), 32'd1);
        if (bus.awready) sb_q.push_back('{id: 4'h3, resp: 2'b00});
        advance();
        bus.awvalid = 1'b0;
        sample();
        check("t3_wready", 32'(bus.wready), 32'd1);
        advance();
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        drain("t3_drain");

        // Ordered IDs with bready toggling
        toggle_en = 1'b1;
        do_aw(4'h7, 2'b00);
        do_aw(4'h2, 2'b00);
        do_aw(4'h7, 2'b00);
        for (int i = 0; i < 3; i++) do_w(4, -1);
        drain("t4_drain");
        toggle_en  = 1'b0;
        bus.bready = 1'b1;

        // Back-to-back single-beat bursts, one B per cycle
        for (int i = 0; i < 4; i++) do_aw(4'(8 + i), 2'b00);
        bus.wvalid = 1'b1;
        bus.wlast  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("t5_wready", 32'(bus.wready), 32'd1);
            if (i >= 2) check("t5_bvalid", 32'(bus.bvalid), 32'd1);
            advance();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            check("t5_bvalid_tail", 32'(bus.bvalid), 32'd1);
            advance();
        end
        sample();
        check("t5_bvalid_end", 32'(bus.bvalid), 32'd0);
        advance();
        drain("t5_drain");

        // Table-driven bursts
        for (int v = 0; v < 8; v++) begin
            toggle_en = vecs[v].tog;
            if (!vecs[v].tog) bus.bready = 1'b1;
            do_aw(vecs[v].id, vecs[v].exp_resp);
            do_w(vecs[v].beats, vecs[v].zero_beat);
        end
        drain("tbl_drain");
        toggle_en  = 1'b0;
        bus.bready = 1'b1;

        // Reset with responses pending and bvalid high
        bus.bready = 1'b0;
        for (int i = 0; i < 3; i++) do_aw(4'(4 + i), 2'b00);
        for (int i = 0; i < 3; i++) do_w(1, -1);
        for (int n = 0; n <= TIMEOUT; n++) begin
            sample();
            if (bus.bvalid) break;
            if (n == TIMEOUT) timeout("t6_bvalid");
            advance();
        end
        check("t6_bvalid_pre", 32'(bus.bvalid), 32'd1);
        advance();
        reset = 1'b1;
        #1;
        check("t6_bvalid_rst", 32'(bus.bvalid), 32'd0);
        check("t6_outstanding_rst", 32'(bus.outstanding), 32'd0);
        check("t6_wready_rst", 32'(bus.wready), 32'd0);
        check("t6_awready_rst", 32'(bus.awready), 32'd1);
        sb_q.delete();
        repeat (2) cycle();
        reset      = 1'b0;
        bus.bready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample();
            check("t6_no_b", 32'(bus.bvalid), 32'd0);
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
